// File: rtl/rock_pkg.sv
// rock_pkg: shared types and helpers for the rock_drive cradle motor sequencer.
//   state_e        : sequencer state (StIdle, StSwing, StDead).
//   LevelW         : width of the amplitude/frequency level inputs.
//   calc_half_len  : ticks per half-swing for a frequency level.
//   calc_drive_len : drive ticks per half-swing, capped at the half-swing length.
package rock_pkg;

    localparam int unsigned LevelW = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSwing = 2'd1,
        StDead  = 2'd2
    } state_e;

    // Computed at 32 bits so the level x step products can never truncate.
    function automatic logic [31:0] calc_half_len(input logic [LevelW-1:0] f,
                                                  input int unsigned step_ticks);
        return (32'd8 - 32'(f)) * step_ticks;
    endfunction

    function automatic logic [31:0] calc_drive_len(input logic [LevelW-1:0] a,
                                                   input logic [LevelW-1:0] f,
                                                   input int unsigned step_ticks,
                                                   input int unsigned pulse_ticks);
        logic [31:0] drive;
        logic [31:0] half;
        drive = 32'(a) * pulse_ticks;
        half  = calc_half_len(f, step_ticks);
        return (drive < half) ? drive : half;
    endfunction

endpackage

// File: rtl/rock_drive_if.sv
// rock_drive_if: level inputs and H-bridge outputs of rock_drive.
//   A, F      : amplitude / frequency level (0..7), driven by the level register.
//   F0        : stop request (high when F == 0).
//   motor_en  : H-bridge enable.
//   motor_dir : 1 = forward half-swing, 0 = reverse.
//   half_done : one-cycle pulse at the end of each half-swing.
//   running   : high while the sequencer is not idle.
// Modports: master = level source / observer, slave = rock_drive.
interface rock_drive_if;
    import rock_pkg::*;

    logic [LevelW-1:0] A;
    logic [LevelW-1:0] F;
    logic              F0;
    logic              motor_en;
    logic              motor_dir;
    logic              half_done;
    logic              running;

    modport master (
        output A, F, F0,
        input  motor_en, motor_dir, half_done, running
    );

    modport slave (
        input  A, F, F0,
        output motor_en, motor_dir, half_done, running
    );

endinterface

// File: rtl/rock_prescaler.sv
// rock_prescaler: divides clk down to a one-cycle tick_en_o every PRESCALE cycles.
//   clk       : system clock.
//   reset     : synchronous active-high reset.
//   clr_i     : synchronous clear; holds the count at 0 and suppresses ticks.
//   tick_en_o : high for one cycle when the count reaches PRESCALE-1.
module rock_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_en_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] Last = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == Last)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_en_o = !clr_i && (cnt_q == Last);

endmodule

// File: rtl/rock_drive.sv
// rock_drive: cradle rocking sequencer. Latches A/F once per half-swing and produces
// direction, enable and half-swing beat for the H-bridge.
//   clk   : system clock.
//   reset : synchronous active-high reset.
//   bus   : rock_drive_if.slave (A, F, F0 in; motor_en, motor_dir, half_done, running out).
// Parameters: PRESCALE clk/tick, STEP_TICKS ticks per frequency step, PULSE_TICKS drive
// ticks per amplitude step, DEAD_TICKS dead-time ticks.
// Optional: define ROCK_DEADTIME_EN to insert a DEAD_TICKS undriven gap at each reversal.
module rock_drive
    import rock_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned STEP_TICKS  = 100,
    parameter int unsigned PULSE_TICKS = 40,
    parameter int unsigned DEAD_TICKS  = 5
) (
    input  logic         clk,
    input  logic         reset,
    rock_drive_if.slave  bus
);

    // Counter covers the longest half-swing (F=0 worst case) and the dead time.
    localparam int unsigned CntMax = (8 * STEP_TICKS > DEAD_TICKS) ? 8 * STEP_TICKS : DEAD_TICKS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     half_cnt_q, half_cnt_d;
    logic [LevelW-1:0]   a_l_q, a_l_d;
    logic [LevelW-1:0]   f_l_q, f_l_d;
    logic                motor_en_q, motor_en_d;
    logic                dir_q, dir_d;
    logic                half_done_q, half_done_d;
    logic                running_q, running_d;
    logic                tick_en;
    logic [31:0]         half_len;
    logic [31:0]         cnt32;

    rock_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == StIdle),
        .tick_en_o (tick_en)
    );

    assign half_len = calc_half_len(f_l_q, STEP_TICKS);
    assign cnt32    = 32'(half_cnt_q);

    always_comb begin
        state_d     = state_q;
        half_cnt_d  = half_cnt_q;
        a_l_d       = a_l_q;
        f_l_d       = f_l_q;
        dir_d       = dir_q;
        half_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.F0) begin
                    state_d    = StSwing;
                    dir_d      = 1'b1;
                    a_l_d      = bus.A;
                    f_l_d      = bus.F;
                    half_cnt_d = '0;
                end
            end
            StSwing: begin
                if (tick_en) begin
                    if (cnt32 == half_len - 32'd1) begin
                        half_done_d = 1'b1;
                        half_cnt_d  = '0;
                        if (bus.F0) begin
                            // Stop keeps the last direction.
                            state_d = StIdle;
                        end else begin
                            dir_d = !dir_q;
`ifdef ROCK_DEADTIME_EN
                            state_d = StDead;
`else
                            a_l_d = bus.A;
                            f_l_d = bus.F;
`endif
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + CntW'(1);
                    end
                end
            end
`ifdef ROCK_DEADTIME_EN
            StDead: begin
                if (tick_en) begin
                    if (cnt32 == DEAD_TICKS - 32'd1) begin
                        half_cnt_d = '0;
                        if (bus.F0) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StSwing;
                            a_l_d   = bus.A;
                            f_l_d   = bus.F;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + CntW'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are computed from next-state values so they are registered, yet
        // still line up with the state/count they describe.
        motor_en_d = (state_d == StSwing) &&
                     (32'(half_cnt_d) < calc_drive_len(a_l_d, f_l_d, STEP_TICKS, PULSE_TICKS));
        running_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            half_cnt_q  <= '0;
            a_l_q       <= '0;
            f_l_q       <= '0;
            motor_en_q  <= 1'b0;
            dir_q       <= 1'b0;
            half_done_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            a_l_q       <= a_l_d;
            f_l_q       <= f_l_d;
            motor_en_q  <= motor_en_d;
            dir_q       <= dir_d;
            half_done_q <= half_done_d;
            running_q   <= running_d;
        end
    end

    assign bus.motor_en  = motor_en_q;
    assign bus.motor_dir = dir_q;
    assign bus.half_done = half_done_q;
    assign bus.running   = running_q;

endmodule

// File: doc/rock_drive.md
# rock_drive

Motor drive sequencer directly downstream of the amplitude/frequency level register. It consumes the 3-bit amplitude level `A`, frequency level `F` and the `F0` flag, and turns them into an alternating rocking motion for the cradle H-bridge: direction, motor-enable and a half-swing beat. Levels are sampled once per half-swing, so level changes never distort a swing already in progress.

## Interface
- `PRESCALE`, 50000: clk cycles per tick (1 ms at 50 MHz).
- `STEP_TICKS`, 100: ticks per frequency step; half-swing = (8 − F) × STEP_TICKS ticks.
- `PULSE_TICKS`, 40: drive ticks per amplitude step.
- `DEAD_TICKS`, 5: dead-time ticks; used only with `ROCK_DEADTIME_EN`.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `A`  in  3  amplitude level, 0..7.
- `F`  in  3  frequency level, 0..7.
- `F0`  in  1  high when F == 0; requests stop.
- `motor_en`  out  1  H-bridge enable.
- `motor_dir`  out  1  1 = forward half-swing, 0 = reverse.
- `half_done`  out  1  one-cycle pulse at end of each half-swing.
- `running`  out  1  high while not IDLE.

## Operation
- Reset values: `motor_en`=0, `motor_dir`=0, `half_done`=0, `running`=0; state IDLE; all counters 0.
- States: IDLE, SWING (plus DEAD with macro).
- IDLE: if `F0`=0 at an edge, the next state is SWING. At that edge: `motor_dir`←1, A_l←A, F_l←F, tick and half counters←0.
- Tick prescaler runs only outside IDLE and restarts at 0 on every entry to SWING. `tick_en` pulses when the count reaches PRESCALE−1.
- SWING: `half_cnt` increments on `tick_en`. Let half_len = (8 − F_l) × STEP_TICKS and drive_len = min(A_l × PULSE_TICKS, half_len).
- `motor_en` = (state==SWING) && (`half_cnt` < drive_len). It is decoded from registers only and has no combinational path from any input.
- End of half-swing (`tick_en` && `half_cnt` == half_len−1):
  - `half_done`←1 for one cycle.
  - If `F0`=0: flip `motor_dir`, relatch A_l and F_l, `half_cnt`←0.
  - If `F0`=1: go to IDLE; `motor_dir` keeps its value.
- A_l=0: no drive in that half-swing; the swing is still timed and `half_done` still pulses.
- Changes to `A` or `F` mid-swing take effect only at the next half-swing boundary.
- `F0` asserted mid-swing: the current half-swing completes, driven as latched, and the block then goes to IDLE.
- Reset asserted mid-swing: all outputs reach their reset values at the next edge.
- Widths: `half_cnt` ≥ clog2(7 × STEP_TICKS). The product A_l × PULSE_TICKS is computed at ≥ clog2(7 × PULSE_TICKS + 1) bits and must not truncate.

## Timing
- IDLE→SWING latency: 1 clk after `F0` is sampled low. `running`, `motor_dir`=1 and `motor_en` (if A_l>0) are visible in the first SWING cycle.
- First tick arrives PRESCALE cycles after SWING entry.
- Half-swing period is exactly half_len × PRESCALE clks. `half_done` coincides with the first cycle of the next half-swing, or with the first IDLE cycle.
- With A_l × PULSE_TICKS ≥ half_len, `motor_en` stays high continuously across reversals.

## Configuration
- `ROCK_DEADTIME_EN` defined:
  - At every half-swing end with `F0`=0, the state goes to DEAD for DEAD_TICKS ticks with `motor_en`=0.
  - `motor_dir` flips on entry to DEAD.
  - A_l and F_l are relatched on the DEAD→SWING transition.
  - `half_done` timing is unchanged.
  - Reversal never coincides with drive.
- Not defined: no DEAD state; the DEAD_TICKS parameter is ignored.

## Structure
- Package `rock_pkg`:
  - state enum (IDLE, SWING, DEAD);
  - level width constant (3);
  - function computing half_len and drive_len from levels and parameters.
- Sub-module `rock_prescaler`: clk→`tick_en` divider with synchronous clear; instantiated once.

## Test plan
Bench parameters: PRESCALE=4, STEP_TICKS=2, PULSE_TICKS=1, DEAD_TICKS=1.
- Reset held with A=5, F=5, F0=0 → all outputs 0; 1 clk after release: `running`=1, `motor_dir`=1.
- F=6, A=2 → `motor_en` high 8 clks, low 8 clks, `half_done` pulse, `motor_dir` flips; pattern repeats every 16 clks.
- A=0, F=6 → `motor_en` never high; `half_done` every 16 clks; `motor_dir` toggles.
- A=7, F=7 → drive capped at 8 clks, equal to the whole half-swing; `motor_en` continuously high without macro, with a 4-clk low gap per reversal with `ROCK_DEADTIME_EN`.
- F changed 6→7 mid-swing → current half-swing stays 16 clks; next is 8 clks.
- F0 raised mid-swing → swing completes, `half_done` pulses, IDLE with `running`=0, `motor_en`=0. Reset mid-swing → all outputs 0 on the next edge.
